// File: rtl/sbox_share_ctrl.sv
// Shared AES S-box bank, time-multiplexed between a 128-bit state job
// and a 32-bit key SubWord job, with round-robin arbitration between them.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   st_req_*            state job request (valid/ready, 128-bit data)
//   st_rsp_*            state response (one-cycle valid pulse, data held)
//   key_req_*           key SubWord request (valid/ready, 32-bit word)
//   key_rsp_*           key response (one-cycle valid pulse, word held)
//   busy                high while a job is in progress
//
// Build option: SBOX_KEY_PRIO_EN gives the key requester fixed priority.
module sbox_share_ctrl #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  output logic [127:0] st_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_word,
  output logic         key_rsp_valid,
  output logic [31:0]  key_rsp_word,
  output logic         busy
);

  localparam int ST_BEATS  = 16 / NUM_SBOX;
  localparam int KEY_BEATS = 4 / NUM_SBOX;
  localparam int CNT_W =
    (ST_BEATS > 1) ? $clog2(ST_BEATS) : 1;
  localparam logic [CNT_W-1:0] ST_LAST =
    CNT_W'(ST_BEATS - 1);
  localparam logic [CNT_W-1:0] KEY_LAST =
    CNT_W'(KEY_BEATS - 1);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 ||
        NUM_SBOX == 4)) begin : g_bad_num_sbox
    $error("sbox_share_ctrl: NUM_SBOX must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN_ST,
    RUN_KEY
  } state_e;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    logic [7:0] r;
    s = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
           {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   st_rsp_q, st_rsp_d;
  logic [31:0]    key_rsp_q, key_rsp_d;
  logic           st_vld_q, st_vld_d;
  logic           key_vld_q, key_vld_d;
  logic           gnt_st, gnt_key;
  logic [6:0]     bit_idx;

`ifdef SBOX_KEY_PRIO_EN
  always_comb begin
    gnt_st  = st_req_valid && !key_req_valid;
    gnt_key = key_req_valid;
  end
`else
  // 1 = last accepted job was a key job.
  logic last_q, last_d;

  always_comb begin
    gnt_st  = st_req_valid;
    gnt_key = key_req_valid;
    if (st_req_valid && key_req_valid) begin
      gnt_key = !last_q;
      gnt_st  = last_q;
    end
  end

  always_comb begin
    last_d = last_q;
    if (st_req_ready)  last_d = 1'b0;
    if (key_req_ready) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b0;
    else        last_q <= last_d;
  end
`endif

  assign st_req_ready  = (state_q == IDLE) && gnt_st;
  assign key_req_ready = (state_q == IDLE) && gnt_key;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    st_rsp_d  = st_rsp_q;
    key_rsp_d = key_rsp_q;
    st_vld_d  = 1'b0;
    key_vld_d = 1'b0;
    bit_idx   = 7'd0;
    unique case (state_q)
      IDLE: begin
        if (st_req_ready) begin
          work_d  = st_req_data;
          cnt_d   = '0;
          state_d = RUN_ST;
        end else if (key_req_ready) begin
          work_d  = {96'h0, key_req_word};
          cnt_d   = '0;
          state_d = RUN_KEY;
        end
      end
      RUN_ST, RUN_KEY: begin
        // Substitute this beat's bytes in place.
        for (int j = 0; j < NUM_SBOX; j++) begin
          bit_idx = 7'(8 * (int'(cnt_q) * NUM_SBOX + j));
          work_d[bit_idx +: 8] = sbox(work_q[bit_idx +: 8]);
        end
        cnt_d = cnt_q + 1'b1;
        if (state_q == RUN_ST && cnt_q == ST_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          st_rsp_d = work_d;
          st_vld_d = 1'b1;
        end
        if (state_q == RUN_KEY && cnt_q == KEY_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          key_rsp_d = work_d[31:0];
          key_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      st_rsp_q  <= '0;
      key_rsp_q <= '0;
      st_vld_q  <= 1'b0;
      key_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      st_rsp_q  <= st_rsp_d;
      key_rsp_q <= key_rsp_d;
      st_vld_q  <= st_vld_d;
      key_vld_q <= key_vld_d;
    end
  end

  assign st_rsp_valid  = st_vld_q;
  assign st_rsp_data   = st_rsp_q;
  assign key_rsp_valid = key_vld_q;
  assign key_rsp_word  = key_rsp_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: NUM_SBOX=4 instance (a_*)
// and NUM_SBOX=1 instance (b_*), sharing clock and reset.
module tb_sbox_share_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_sv, a_sr, a_srv, a_kv, a_kr, a_krv, a_busy;
  logic [127:0] a_sd, a_srd;
  logic [31:0] a_kw, a_krw;
  logic b_sv, b_sr, b_srv, b_kv, b_kr, b_krv, b_busy;
  logic [127:0] b_sd, b_srd;
  logic [31:0] b_kw, b_krw;

  int checks = 0;
  int errors = 0;

  sbox_share_ctrl #(.NUM_SBOX(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(a_sv), .st_req_ready(a_sr),
    .st_req_data(a_sd),
    .st_rsp_valid(a_srv), .st_rsp_data(a_srd),
    .key_req_valid(a_kv), .key_req_ready(a_kr),
    .key_req_word(a_kw),
    .key_rsp_valid(a_krv), .key_rsp_word(a_krw),
    .busy(a_busy)
  );

  sbox_share_ctrl #(.NUM_SBOX(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(b_sv), .st_req_ready(b_sr),
    .st_req_data(b_sd),
    .st_rsp_valid(b_srv), .st_rsp_data(b_srd),
    .key_req_valid(b_kv), .key_req_ready(b_kr),
    .key_req_word(b_kw),
    .key_rsp_valid(b_krv), .key_rsp_word(b_krw),
    .busy(b_busy)
  );

  task automatic chk1(input string tag,
                      input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] SEQ   =
    128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SEQ_S =
    128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [31:0] KW   = 32'hcf4f3c09;
  localparam logic [31:0] KW_S = 32'h8a84eb01;

  logic e_kr, e_sr, e_krv, e_srv;

  initial begin
    a_sv = 0; a_sd = '0; a_kv = 0; a_kw = '0;
    b_sv = 0; b_sd = '0; b_kv = 0; b_kw = '0;
    #2;
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_st_vld", a_srv, 1'b0);
    chk1("rst_key_vld", a_krv, 1'b0);
    chkw("rst_st_data", a_srd, '0);
    chkw("rst_key_word", {96'h0, a_krw}, '0);
    chk1("rst_st_ready", a_sr, 1'b0);
    tick; tick;
    rst_n = 1'b1;

    // 1: state job alone, all-zero data
    tick;
    a_sv = 1; a_sd = '0; #1;
    chk1("t1_st_ready", a_sr, 1'b1);
    chk1("t1_key_ready", a_kr, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tick; a_sv = 0; #1;
      chk1("t1_busy", a_busy, c <= 4);
      chk1("t1_st_vld", a_srv, c == 5);
      chk1("t1_st_ready_run", a_sr, 1'b0);
      if (c >= 5) chkw("t1_st_data", a_srd, ALL63);
    end

    // 2: key job alone
    tick;
    a_kv = 1; a_kw = KW; #1;
    chk1("t2_key_ready", a_kr, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick; a_kv = 0; #1;
      chk1("t2_busy", a_busy, c == 1);
      chk1("t2_key_vld", a_krv, c == 2);
      if (c == 2) chkw("t2_key_word", {96'h0, a_krw}, {96'h0, KW_S});
    end

    // 3: both valid from reset
    rst_n = 0; #1;
    chkw("t3_rst_key_word", {96'h0, a_krw}, '0);
    tick; tick;
    rst_n = 1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick;
      a_sv = 1; a_sd = '0; a_kv = 1; a_kw = KW; #1;
`ifdef SBOX_KEY_PRIO_EN
      e_kr = (c % 2 == 0);
      e_sr = 1'b0;
      e_krv = (c % 2 == 0) && c >= 2;
      e_srv = 1'b0;
`else
      e_kr = (c == 0) || (c == 7);
      e_sr = (c == 2) || (c == 9);
      e_krv = (c == 2) || (c == 9);
      e_srv = (c == 7);
`endif
      chk1("t3_key_ready", a_kr, e_kr);
      chk1("t3_st_ready", a_sr, e_sr);
      chk1("t3_key_vld", a_krv, e_krv);
      chk1("t3_st_vld", a_srv, e_srv);
      if (e_krv) chkw("t3_key_word", {96'h0, a_krw}, {96'h0, KW_S});
      if (e_srv) chkw("t3_st_data", a_srd, ALL63);
    end
    a_sv = 0; a_kv = 0;
    for (int c = 0; c < 8; c++) tick;
    chk1("t3_idle", a_busy, 1'b0);

    // 4: reset in cycle 2 of a state job
    a_sv = 1; a_sd = SEQ; #1;
    chk1("t4_st_ready", a_sr, 1'b1);
    tick; a_sv = 0;
    tick;
    rst_n = 0; #1;
    chk1("t4_busy", a_busy, 1'b0);
    chk1("t4_st_vld", a_srv, 1'b0);
    chkw("t4_st_data", a_srd, '0);
    tick;
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk1("t4_no_rsp", a_srv, 1'b0);
      chk1("t4_no_busy", a_busy, 1'b0);
    end
    a_sv = 1; a_sd = SEQ; #1;
    chk1("t4b_st_ready", a_sr, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick; a_sv = 0; #1;
      chk1("t4b_st_vld", a_srv, c == 5);
      if (c == 5) chkw("t4b_st_data", a_srd, SEQ_S);
    end

    // 6: NUM_SBOX=1 instance
    tick;
    b_sv = 1; b_sd = {16{8'h53}}; #1;
    chk1("t6_st_ready", b_sr, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      tick; b_sv = 0; #1;
      chk1("t6_busy", b_busy, c <= 16);
      chk1("t6_st_vld", b_srv, c == 17);
      if (c == 17) chkw("t6_st_data", b_srd, {16{8'hed}});
    end
    b_kv = 1; b_kw = {4{8'h53}}; #1;
    chk1("t6_key_ready", b_kr, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      tick; b_kv = 0; #1;
      chk1("t6_key_vld", b_krv, c == 5);
      if (c == 5)
        chkw("t6_key_word", {96'h0, b_krw}, {96'h0, {4{8'hed}}});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
